// File: rtl/bvudiv_pkg.sv
// Shared types and constants for the unsigned divide witness checker.
package bvudiv_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bvudiv_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor and keep the difference if no borrow.
module bvudiv_step
    import bvudiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   prem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH:0]   prem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtract one bit wider than the shifted remainder so its MSB is the borrow.
    always_comb begin
        shifted   = (prem << 1) | {{WIDTH{1'b0}}, next_bit};
        diff      = {1'b0, shifted} - {2'b00, divisor};
        q_bit     = ~diff[WIDTH+1];
        prem_next = q_bit ? diff[WIDTH:0] : shifted;
    end

endmodule

// File: rtl/bvudiv_witness_checker.sv
// Computes bvudiv/bvurem of a registered operand pair and checks a candidate
// quotient against the result.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; in_ready = 1
// DIV   | WIDTH restoring iterations, MSB first, counter runs down
// DONE  | result presented; out_valid = 1 until out_ready
module bvudiv_witness_checker
    import bvudiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] cand_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             match
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] cand_r;
    // Candidate captured together with the result so match holds outside DONE.
    logic [WIDTH-1:0] cand_done;
    logic             have_result;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign match     = have_result && (cand_done == quotient);

    bvudiv_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .divisor   (dvs_r),
        .next_bit  (dvd_sh[WIDTH-1]),
        .prem_next (step_rem),
        .q_bit     (step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode; divide-by-zero skips the iteration phase entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (divisor == '0) ? DONE : DIV;
            DIV:     if (cnt == CNT_LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            prem        <= '0;
            dvd_sh      <= '0;
            dvs_r       <= '0;
            cand_r      <= '0;
            cand_done   <= '0;
            have_result <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_sh <= dividend;
                        dvs_r  <= divisor;
                        cand_r <= cand_q;
                        prem   <= '0;
                        cnt    <= CNT_LOAD;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            cand_done   <= cand_q;
                            have_result <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    prem   <= step_rem;
                    dvd_sh <= {dvd_sh[WIDTH-2:0], step_q};
                    cnt    <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        quotient    <= {dvd_sh[WIDTH-2:0], step_q};
                        remainder   <= step_rem[WIDTH-1:0];
                        cand_done   <= cand_r;
                        have_result <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
